// File: rtl/alu_operand_sequencer_if.sv
// Board-side bundle for the ALU operand sequencer: switches, button, ALU
// result/flags in, registered operands and captured result out.
interface alu_operand_sequencer_if #(
  parameter int COUNT_W = 8
);
  logic [3:0]         sw;
  logic               btn;
  logic [3:0]         alu_result;
  logic               alu_z, alu_c, alu_v, alu_s;
  logic [3:0]         op_a, op_b;
  logic [1:0]         op_sel;
  logic [3:0]         res_q, flags_q;
  logic [2:0]         state_q;
  logic               res_valid;
  logic [COUNT_W-1:0] op_count;

  modport master (
    output sw, btn, alu_result, alu_z, alu_c, alu_v, alu_s,
    input  op_a, op_b, op_sel, res_q, flags_q, state_q, res_valid, op_count
  );
  modport slave (
    input  sw, btn, alu_result, alu_z, alu_c, alu_v, alu_s,
    output op_a, op_b, op_sel, res_q, flags_q, state_q, res_valid, op_count
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Button-driven operand/opcode capture for a 4-bit combinational ALU, with a
// registered result and flag snapshot taken one settle cycle after launch.
module alu_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COUNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  alu_operand_sequencer_if.slave bus
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [2:0] LOAD_A  = 3'd0;
  localparam logic [2:0] LOAD_B  = 3'd1;
  localparam logic [2:0] LOAD_OP = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] SHOW    = 3'd5;

  logic               btn_m, btn_s, btn_db, btn_db_d, press;
  logic [CW-1:0]      db_cnt;
  logic [2:0]         state;
  logic [3:0]         a_r, b_r, res_r, flg_r;
  logic [1:0]         sel_r;
  logic               vld_r;
  logic [COUNT_W-1:0] cnt_r;

  // Two-flop synchronizer, run-length debounce, and rising-edge press pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_m    <= 1'b0;
      btn_s    <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      press    <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_m    <= bus.btn;
      btn_s    <= btn_m;
      btn_db_d <= btn_db;
      press    <= btn_db & ~btn_db_d;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

  // EXEC/CAPTURE never look at press, so a pulse there is simply lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_A;
      a_r   <= '0;
      b_r   <= '0;
      sel_r <= '0;
      res_r <= '0;
      flg_r <= '0;
      vld_r <= 1'b0;
      cnt_r <= '0;
    end else begin
      case (state)
        LOAD_A: if (press) begin
          a_r   <= bus.sw;
          vld_r <= 1'b0;
          state <= LOAD_B;
        end
        LOAD_B: if (press) begin
          b_r   <= bus.sw;
          state <= LOAD_OP;
        end
        LOAD_OP: if (press) begin
          sel_r <= bus.sw[1:0];
          state <= EXEC;
        end
        EXEC: state <= CAPTURE;
        CAPTURE: begin
          res_r <= bus.alu_result;
          flg_r <= {bus.alu_z, bus.alu_c, bus.alu_v, bus.alu_s};
          vld_r <= 1'b1;
          cnt_r <= cnt_r + COUNT_W'(1);
          state <= SHOW;
        end
        SHOW: if (press) state <= LOAD_A;
        default: state <= LOAD_A;
      endcase
    end
  end

  assign bus.op_a      = a_r;
  assign bus.op_b      = b_r;
  assign bus.op_sel    = sel_r;
  assign bus.res_q     = res_r;
  assign bus.flags_q   = flg_r;
  assign bus.state_q   = state;
  assign bus.res_valid = vld_r;
  assign bus.op_count  = cnt_r;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench: button-level stimulus, an ideal ALU, a spec-level model
// compared every cycle, and literal pins on key outcomes.
module tb_alu_operand_sequencer;
  localparam int DB = 4;
  localparam int CWD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_operand_sequencer_if #(.COUNT_W(CWD)) bus ();

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(DB), .COUNT_W(CWD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int nprint = 0;

  // Ideal ALU: returns {result, Z, C, V, S}; C on subtract means no borrow
  function automatic logic [7:0] alu(input logic [3:0] a, input logic [3:0] b,
                                     input logic [1:0] sel);
    logic [4:0] w;
    logic [3:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0;
    case (sel)
      2'b00: begin
        w = {1'b0, a} + {1'b0, b}; r = w[3:0]; c = w[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      2'b01: begin
        w = {1'b0, a} - {1'b0, b}; r = w[3:0]; c = ~w[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      2'b10: r = a & b;
      default: r = a | b;
    endcase
    return {r, (r == 4'd0), c, v, r[3]};
  endfunction

  assign {bus.alu_result, bus.alu_z, bus.alu_c, bus.alu_v, bus.alu_s} =
    alu(bus.op_a, bus.op_b, bus.op_sel);

  // Spec-level model: button level must differ for DB straight cycles after a
  // 2-cycle sync delay; press is seen the cycle after the debounced rise.
  logic [3:0]     m_a = '0, m_b = '0, m_res = '0, m_flg = '0;
  logic [1:0]     m_sel = '0;
  logic [CWD-1:0] m_cnt = '0;
  logic           m_vld = 1'b0;
  int             m_step = 0;
  logic           m_m = 1'b0, m_s = 1'b0, m_db = 1'b0, m_db_d = 1'b0, m_press = 1'b0;
  int             m_run = 0;

  always @(posedge clk or posedge rst) begin
    logic [7:0] r;
    logic nxt;
    if (rst) begin
      m_a = '0; m_b = '0; m_res = '0; m_flg = '0; m_sel = '0; m_cnt = '0;
      m_vld = 1'b0; m_step = 0; m_m = 1'b0; m_s = 1'b0; m_db = 1'b0;
      m_db_d = 1'b0; m_press = 1'b0; m_run = 0;
    end else begin
      case (m_step)
        0: if (m_press) begin m_a = bus.sw; m_vld = 1'b0; m_step = 1; end
        1: if (m_press) begin m_b = bus.sw; m_step = 2; end
        2: if (m_press) begin m_sel = bus.sw[1:0]; m_step = 3; end
        3: m_step = 4;
        4: begin
          r = alu(m_a, m_b, m_sel);
          m_res = r[7:4]; m_flg = r[3:0]; m_vld = 1'b1;
          m_cnt = m_cnt + 1'b1; m_step = 5;
        end
        default: if (m_press) m_step = 0;
      endcase
      nxt = m_db && !m_db_d;
      m_db_d = m_db;
      if (m_s != m_db) begin
        m_run++;
        if (m_run == DB) begin m_db = m_s; m_run = 0; end
      end else m_run = 0;
      m_s = m_m;
      m_m = bus.btn;
      m_press = nxt;
    end
  end

  always @(negedge clk) begin
    logic [23:0] got, exp;
    got = {bus.op_a, bus.op_b, bus.op_sel, bus.res_q, bus.flags_q, bus.state_q,
           bus.res_valid, bus.op_count};
    exp = {m_a, m_b, m_sel, m_res, m_flg, m_step[2:0], m_vld, m_cnt};
    total++;
    if (got !== exp) begin
      bad++;
      if (nprint < 20) $display("FAIL cycle_model t=%0t got=%06h want=%06h", $time, got, exp);
      nprint++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.state_q == s) return;
    end
    chk("wait_state_timeout", {29'd0, bus.state_q}, {29'd0, s});
  endtask

  task automatic press(input logic [3:0] v);
    @(negedge clk);
    bus.sw = v; bus.btn = 1'b1;
    repeat (DB + 8) @(negedge clk);
    bus.btn = 1'b0;
    repeat (DB + 6) @(negedge clk);
  endtask

  // Opcode press that also forces a spurious pulse while in EXEC
  task automatic press_inj(input logic [3:0] v);
    @(negedge clk);
    bus.sw = v; bus.btn = 1'b1;
    wait_state(3'd3, DB + 12);
    force dut.press = 1'b1;
    @(negedge clk);
    release dut.press;
    repeat (DB + 4) @(negedge clk);
    bus.btn = 1'b0;
    repeat (DB + 6) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_opa"}, {28'd0, bus.op_a}, 32'd0);
    chk({nm, "_opb"}, {28'd0, bus.op_b}, 32'd0);
    chk({nm, "_sel"}, {30'd0, bus.op_sel}, 32'd0);
    chk({nm, "_res"}, {28'd0, bus.res_q}, 32'd0);
    chk({nm, "_flg"}, {28'd0, bus.flags_q}, 32'd0);
    chk({nm, "_st"},  {29'd0, bus.state_q}, 32'd0);
    chk({nm, "_vld"}, {31'd0, bus.res_valid}, 32'd0);
    chk({nm, "_cnt"}, {30'd0, bus.op_count}, 32'd0);
  endtask

  initial begin
    logic [3:0] wa[4], wb[4], wo[4];
    int ec[4];
    wa = '{4'd2, 4'd12, 4'd4, 4'd15};
    wb = '{4'd9, 4'd10, 4'd5, 4'd1};
    wo = '{4'b0010, 4'b0011, 4'b1000, 4'b0101};
    ec = '{1, 2, 3, 0};
    bus.sw = '0; bus.btn = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean press: pulse in cycle 7, state moves at the edge ending it
    bus.sw = 4'd7; bus.btn = 1'b1;
    repeat (7) @(posedge clk);
    #1 chk("press_lat_before", {29'd0, bus.state_q}, 32'd0);
    @(posedge clk);
    #1 chk("press_lat_after", {29'd0, bus.state_q}, 32'd1);
    repeat (50) @(negedge clk);
    chk("hold_single_event", {29'd0, bus.state_q}, 32'd1);
    chk("hold_opa", {28'd0, bus.op_a}, 32'd7);
    bus.btn = 1'b0;
    repeat (DB + 6) @(negedge clk);

    // Bounce: 3 high / 2 low never survives debounce
    bus.sw = 4'd9;
    for (int k = 0; k < 5; k++) begin
      bus.btn = 1'b1; repeat (3) @(negedge clk);
      bus.btn = 1'b0; repeat (2) @(negedge clk);
    end
    repeat (DB + 6) @(negedge clk);
    chk("bounce_state", {29'd0, bus.state_q}, 32'd1);
    chk("bounce_opb", {28'd0, bus.op_b}, 32'd0);

    press(4'b0001);
    press(4'b1100);
    wait_state(3'd5, 20);
    chk("s1_opa", {28'd0, bus.op_a}, 32'd7);
    chk("s1_opb", {28'd0, bus.op_b}, 32'd1);
    chk("s1_sel", {30'd0, bus.op_sel}, 32'd0);
    chk("s1_res", {28'd0, bus.res_q}, 32'h8);
    chk("s1_z", {31'd0, bus.flags_q[3]}, 32'd0);
    chk("s1_c", {31'd0, bus.flags_q[2]}, 32'd0);
    chk("s1_s", {31'd0, bus.flags_q[0]}, 32'd1);
    chk("s1_vld", {31'd0, bus.res_valid}, 32'd1);
    chk("s1_cnt", {30'd0, bus.op_count}, 32'd1);
    chk("s1_st", {29'd0, bus.state_q}, 32'd5);

    press(4'd0);
    chk("show_to_loada", {29'd0, bus.state_q}, 32'd0);
    chk("vld_kept", {31'd0, bus.res_valid}, 32'd1);
    press(4'd3);
    chk("vld_cleared", {31'd0, bus.res_valid}, 32'd0);
    press(4'd3);
    press(4'b0101);
    wait_state(3'd5, 20);
    chk("s2_res", {28'd0, bus.res_q}, 32'd0);
    chk("s2_z", {31'd0, bus.flags_q[3]}, 32'd1);
    chk("s2_sel", {30'd0, bus.op_sel}, 32'd1);
    chk("s2_cnt", {30'd0, bus.op_count}, 32'd2);

    // Reset mid-LOAD_OP takes effect without waiting for a clock
    press(4'd0);
    press(4'd5);
    press(4'd6);
    chk("pre_rst_opa", {28'd0, bus.op_a}, 32'd5);
    chk("pre_rst_st", {29'd0, bus.state_q}, 32'd2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      press(wa[k]);
      press(wb[k]);
      if (k == 0) press_inj(wo[k]);
      else press(wo[k]);
      wait_state(3'd5, 20);
      chk("wrap_cnt", {30'd0, bus.op_count}, ec[k]);
      if (k < 3) press(4'd0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
